// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_SECOND
  } state_t;

  // Stores only accept signed widths; loads also accept the unsigned ones.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] code);
    logic ok;
    ok = (code == F3_B) || (code == F3_H) || (code == F3_W);
    if (!is_store) begin
      ok = ok || (code == F3_BU) || (code == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane alignment: access size, split detection, store merge
// into one memory word and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic        hi_part,
  input  logic [31:0] old_word,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic        split,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [2:0]  size;
  logic [3:0]  size_mask;
  logic [7:0]  byte_mask;
  logic [63:0] shifted_data;
  logic [63:0] load_window;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;

  // Decode access size in bytes and its right-justified byte mask.
  always_comb begin
    size      = 3'd4;
    size_mask = 4'b1111;
    case (funct3)
      F3_B, F3_BU: begin
        size      = 3'd1;
        size_mask = 4'b0001;
      end
      F3_H, F3_HU: begin
        size      = 3'd2;
        size_mask = 4'b0011;
      end
      default: begin
        size      = 3'd4;
        size_mask = 4'b1111;
      end
    endcase
  end

  assign split        = (({1'b0, offset} + size) > 3'd4);
  assign byte_mask    = {4'b0000, size_mask} << offset;
  assign shifted_data = {32'h0, wdata} << {offset, 3'b000};

  // Merge the shifted store lanes of the selected half into the word just read.
  always_comb begin
    merged_word = old_word;
    lane_mask   = hi_part ? byte_mask[7:4] : byte_mask[3:0];
    lane_data   = hi_part ? shifted_data[63:32] : shifted_data[31:0];
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) begin
        merged_word[8*i +: 8] = lane_data[8*i +: 8];
      end
    end
  end

  assign load_window = {hi_word, lo_word} >> {offset, 3'b000};

  // Keep the low bytes of the shifted window and extend per load type.
  always_comb begin
    load_data = load_window[31:0];
    case (funct3)
      F3_B:    load_data = {{24{load_window[7]}}, load_window[7:0]};
      F3_H:    load_data = {{16{load_window[15]}}, load_window[15:0]};
      F3_BU:   load_data = {24'h0, load_window[7:0]};
      F3_HU:   load_data = {16'h0, load_window[15:0]};
      default: load_data = load_window[31:0];
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end: sequences byte-addressed RV32I accesses onto a
// word-organised memory, splitting word-straddling accesses over two cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              stall,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t              state;
  state_t              next_state;
  logic [31:0]         lo_buf;
  logic                capture_lo;
  logic [ADDR_W-1:0]   word_a;
  logic [ADDR_W-1:0]   word_b;
  logic                legal;
  logic                in_second;
  logic                split;
  logic [31:0]         merged_word;
  logic [31:0]         load_data;
  logic                unused_addr;

  assign word_a      = addr[ADDR_W+1:2];
  assign word_b      = word_a + 1'b1;
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign legal       = f3_legal(req_we, funct3);
  assign in_second   = (state == ST_SECOND);

  lsu_align u_align (
    .funct3      (funct3),
    .offset      (addr[1:0]),
    .wdata       (wdata),
    .hi_part     (in_second),
    .old_word    (mem_rdata),
    .lo_word     (in_second ? lo_buf : mem_rdata),
    .hi_word     (mem_rdata),
    .split       (split),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  // Next state and all outputs; everything is forced idle while reset is held.
  always_comb begin
    next_state = state;
    capture_lo = 1'b0;
    mem_addr   = word_a;
    mem_we     = 1'b0;
    mem_wdata  = 32'h0;
    rdata      = 32'h0;
    ready      = 1'b0;
    err        = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (!legal) begin
              err   = 1'b1;
              ready = 1'b1;
            end else begin
              mem_we    = req_we;
              mem_wdata = req_we ? merged_word : 32'h0;
              if (split) begin
                capture_lo = ~req_we;
                next_state = ST_SECOND;
              end else begin
                ready = 1'b1;
                rdata = req_we ? 32'h0 : load_data;
              end
            end
          end
        end
        ST_SECOND: begin
          mem_addr   = word_b;
          mem_we     = req_we;
          mem_wdata  = req_we ? merged_word : 32'h0;
          rdata      = req_we ? 32'h0 : load_data;
          ready      = 1'b1;
          next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign stall = rst_n & req_valid & ~ready;

  // State register and low-word buffer for split loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      lo_buf <= 32'h0;
    end else begin
      state <= next_state;
      if (capture_lo) begin
        lo_buf <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a bench-owned word memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        err;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  typedef struct {
    logic        is_load;
    logic        exp_err;
    logic [31:0] exp_rdata;
    string       name;
  } exp_t;

  exp_t exp_queue[$];
  exp_t mon_item;
  int   assert_count = 0;
  int   fail_count   = 0;

  load_store_unit #(.ADDR_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .stall     (stall),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory: combinational read, word write on the rising edge, plus a preload port.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge; the write lands on the following edge.
  task automatic preload_word(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  // Issue one op, queue its expected response, and watch latency, stall and writes.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] exp_rd,
                               input logic exp_err, input int exp_cycles,
                               input int exp_writes, input string name);
    exp_t item;
    int   cycles;
    int   writes;
    logic done;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    req_valid = 1'b1;
    item.is_load   = ~we;
    item.exp_err   = exp_err;
    item.exp_rdata = exp_rd;
    item.name      = name;
    exp_queue.push_back(item);
    cycles = 0;
    writes = 0;
    done   = 1'b0;
    while (!done && cycles < 4) begin
      @(negedge clk);
      cycles++;
      if (mem_we) writes++;
      if (ready) begin
        done = 1'b1;
      end else begin
        checkOutput({name, "_stall"}, 32'(stall), 32'd1);
      end
    end
    checkOutput({name, "_latency"}, done ? 32'(cycles) : 32'd99, 32'(exp_cycles));
    checkOutput({name, "_writes"}, 32'(writes), 32'(exp_writes));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Monitor: pop and compare whenever the DUT completes an op.
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (exp_queue.size() == 0) begin
        assert_count++;
        fail_count++;
        $display("[TB] FAIL unexpected_ready: got ready=1, expected no pending op");
      end else begin
        mon_item = exp_queue.pop_front();
        checkOutput({mon_item.name, "_err"}, 32'(err), 32'(mon_item.exp_err));
        if (mon_item.is_load || mon_item.exp_err) begin
          checkOutput({mon_item.name, "_rdata"}, rdata, mon_item.exp_rdata);
        end
        if (mon_item.exp_err) begin
          checkOutput({mon_item.name, "_nowrite"}, 32'(mem_we), 32'd0);
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    pre_we    = 1'b0;
    pre_addr  = 10'h0;
    pre_data  = 32'h0;

    #12;
    checkOutput("rst_ready",  32'(ready),  32'd0);
    checkOutput("rst_stall",  32'(stall),  32'd0);
    checkOutput("rst_err",    32'(err),    32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_rdata",  rdata,       32'h0);
    checkOutput("rst_wdata",  mem_wdata,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 3'b010, 32'h0000_0070, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1, "sw_70");
    checkOutput("mem_1c_sw", mem[10'h1C], 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b010, 32'h0000_0070, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, "lw_70");

    preload_word(10'h1C, 32'h11223344);
    applyStimulus(1'b1, 3'b000, 32'h0000_0072, 32'h0000_00AB, 32'h0, 1'b0, 1, 1, "sb_72");
    checkOutput("mem_1c_sb", mem[10'h1C], 32'h11AB3344);
    applyStimulus(1'b0, 3'b000, 32'h0000_0072, 32'h0, 32'hFFFFFFAB, 1'b0, 1, 0, "lb_72");
    applyStimulus(1'b0, 3'b100, 32'h0000_0072, 32'h0, 32'h000000AB, 1'b0, 1, 0, "lbu_72");
    applyStimulus(1'b0, 3'b001, 32'h0000_0072, 32'h0, 32'h000011AB, 1'b0, 1, 0, "lh_72");
    applyStimulus(1'b0, 3'b101, 32'h0000_0070, 32'h0, 32'h00003344, 1'b0, 1, 0, "lhu_70");

    preload_word(10'd10, 32'h000000AA);
    preload_word(10'd11, 32'hBBCCDDEE);
    applyStimulus(1'b0, 3'b010, 32'h0000_002B, 32'h0, 32'hCCDDEE00, 1'b0, 2, 0, "lw_2b");
    applyStimulus(1'b0, 3'b001, 32'h0000_002B, 32'h0, 32'hFFFFEE00, 1'b0, 2, 0, "lh_2b");

    preload_word(10'd1023, 32'h55667788);
    preload_word(10'd0,    32'h99AABBCC);
    applyStimulus(1'b1, 3'b001, 32'h0000_0FFF, 32'h0000_1234, 32'h0, 1'b0, 2, 2, "sh_fff");
    checkOutput("mem_1023_sh", mem[10'd1023], 32'h34667788);
    checkOutput("mem_0_sh",    mem[10'd0],    32'h99AABB12);

    applyStimulus(1'b0, 3'b011, 32'h0000_0070, 32'h0, 32'h0, 1'b1, 1, 0, "ld_f3_011");
    applyStimulus(1'b1, 3'b100, 32'h0000_0070, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, "st_f3_100");
    checkOutput("mem_1c_after_err", mem[10'h1C], 32'h11AB3344);

    preload_word(10'd20, 32'h01010101);
    preload_word(10'd21, 32'h02020202);
    req_we    = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h0000_0052;
    wdata     = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(negedge clk);
    checkOutput("split_rst_stall1", 32'(stall),  32'd1);
    checkOutput("split_rst_we1",    32'(mem_we), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("split_rst_second_addr", 32'(mem_addr), 32'd21);
    rst_n = 1'b0;
    #1;
    checkOutput("split_rst_ready", 32'(ready),  32'd0);
    checkOutput("split_rst_stall", 32'(stall),  32'd0);
    checkOutput("split_rst_we",    32'(mem_we), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mem_20_kept",    mem[10'd20], 32'hF00D0101);
    checkOutput("mem_21_untouch", mem[10'd21], 32'h02020202);
    applyStimulus(1'b0, 3'b010, 32'h0000_0050, 32'h0, 32'hF00D0101, 1'b0, 1, 0, "lw_50_after_rst");

    @(negedge clk);
    checkOutput("queue_drained", 32'(exp_queue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
